// File: rtl/traffic_pkg.sv
// Shared definitions for the NoC traffic generator: command codes, FSM
// states, descriptor layout and default field widths.
package traffic_pkg;

    localparam int DEF_NUM_PKTS = 1024;
    localparam int DEF_DEST_W   = 14;
    localparam int DEF_VC_W     = 2;
    localparam int DEF_LEN_W    = 10;
    localparam int DEF_GAP_W    = 4;
    localparam int DEF_CNT_W    = 16;

    // Command codes on the op port; any other code behaves as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_INIT  = 3'd5,
        OP_FILL  = 3'd6,
        OP_START = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    // Descriptor as carried on the command data bus for FILL, MSB to LSB.
    typedef struct packed {
        logic [DEF_GAP_W-1:0]  gap;
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_VC_W-1:0]   vc;
        logic [DEF_DEST_W-1:0] dest;
    } desc_t;

    // Number of flits a length field produces: zero still sends one flit.
    function automatic int eff_len(input int len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/traffic_desc_ram.sv
// Descriptor table: one write port, one synchronous read port whose output
// register doubles as the prefetch slot of the traffic generator.
module traffic_desc_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 30,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on FILL, read on demand; rd_data holds its value between reads.
    // NOTE: the array and its read register have no reset so the table maps
    // onto block RAM; non-blocking assignments keep the read-during-write
    // ordering identical in simulation and hardware.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/traffic_gen_mc.sv
// NoC traffic source: loads packet descriptors, then replays them cyclically
// as head/body/tail flits on a valid/ready port until the programmed packet
// total has been sent.
module traffic_gen_mc
    import traffic_pkg::*;
#(
    parameter int NUM_PKTS = DEF_NUM_PKTS,
    parameter int DEST_W   = DEF_DEST_W,
    parameter int VC_W     = DEF_VC_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int GAP_W    = DEF_GAP_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DATA_W   = DEST_W + VC_W + LEN_W + GAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_head,
    output logic              out_tail,
    output logic [VC_W-1:0]   out_vc,
    output logic [DEST_W-1:0] out_dest,
    output logic [LEN_W-1:0]  out_seq,
    output logic              busy,
    output logic              done,
    output logic              fill_err
);

    localparam int             IDX_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int             DESC_W     = DEST_W + VC_W + LEN_W + GAP_W;
    localparam logic [IDX_W:0] TABLE_FULL = (IDX_W + 1)'(NUM_PKTS);

    state_e state, state_nx;

    logic [CNT_W-1:0]  total, sent, sent_inc;
    logic [IDX_W:0]    stored, rd_idx_inc;
    logic [IDX_W-1:0]  rd_idx, rd_idx_nx;
    logic              pf_valid;
    logic [DESC_W-1:0] rd_data;
    logic [GAP_W-1:0]  gap_cnt, cur_gap;
    logic [LEN_W-1:0]  cur_last;
    logic              busy_nx, done_nx;

    // Prefetched descriptor fields, unpacked from the table read register.
    logic [GAP_W-1:0]  pf_gap;
    logic [LEN_W-1:0]  pf_len;
    logic [VC_W-1:0]   pf_vc;
    logic [DEST_W-1:0] pf_dest;

    assign pf_gap  = rd_data[DESC_W-1 -: GAP_W];
    assign pf_len  = rd_data[DEST_W + VC_W +: LEN_W];
    assign pf_vc   = rd_data[DEST_W +: VC_W];
    assign pf_dest = rd_data[0 +: DEST_W];

    logic cmd_init, cmd_fill, cmd_start;
    logic accept, tail_acc, last_pkt;
    logic run_ok, load_out, rd_en, wr_en;

    assign cmd_init  = (op == OP_INIT);
    assign cmd_fill  = (op == OP_FILL)  && (state == ST_LOAD);
    assign cmd_start = (op == OP_START) && (state == ST_LOAD);

    assign accept    = out_valid && out_ready;
    assign tail_acc  = accept && out_tail;
    assign sent_inc  = sent + CNT_W'(1);
    assign last_pkt  = tail_acc && (sent_inc == total);

    // A new head may enter the output register in RUN (unless this tail ends
    // the stream or starts a gap) or on the last cycle of a gap.
    assign run_ok   = ((state == ST_RUN) && !(tail_acc && (last_pkt || cur_gap != '0)))
                   || ((state == ST_GAP) && (gap_cnt == GAP_W'(1)));
    assign load_out = !cmd_init && pf_valid && (!out_valid || tail_acc) && run_ok;

    // Refill the prefetch slot whenever it is empty or being consumed, so
    // zero-gap packets follow each other without a bubble.
    assign rd_en = !cmd_init && ((state == ST_RUN) || (state == ST_GAP))
                && (!pf_valid || load_out);

    assign rd_idx_inc = {1'b0, rd_idx} + (IDX_W + 1)'(1);
    assign rd_idx_nx  = (rd_idx_inc == stored) ? '0 : rd_idx_inc[IDX_W-1:0];

    assign wr_en = cmd_fill && (stored != TABLE_FULL);

    traffic_desc_ram #(
        .DEPTH  (NUM_PKTS),
        .WIDTH  (DESC_W),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (stored[IDX_W-1:0]),
        .wr_data (data[DESC_W-1:0]),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; INIT overrides every state.
    // NOTE: state_nx is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (cmd_init) begin
            state_nx = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (cmd_start) begin
                        state_nx = (total == '0 || stored == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_pkt) begin
                        state_nx = ST_DONE;
                    end else if (tail_acc && cur_gap != '0) begin
                        state_nx = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state_nx = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs follow the next state so they can be registered.
    always_comb begin
        busy_nx = (state_nx == ST_RUN) || (state_nx == ST_GAP);
        done_nx = (state_nx == ST_DONE);
    end

    // Counters, prefetch bookkeeping and the flit output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total     <= '0;
            sent      <= '0;
            stored    <= '0;
            rd_idx    <= '0;
            pf_valid  <= 1'b0;
            gap_cnt   <= '0;
            cur_gap   <= '0;
            cur_last  <= '0;
            out_valid <= 1'b0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
            out_vc    <= '0;
            out_dest  <= '0;
            out_seq   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (cmd_init) begin
                total     <= data[CNT_W-1:0];
                sent      <= '0;
                stored    <= '0;
                fill_err  <= 1'b0;
                rd_idx    <= '0;
                pf_valid  <= 1'b0;
                out_valid <= 1'b0;
                out_head  <= 1'b0;
                out_tail  <= 1'b0;
            end else begin
                if (cmd_fill) begin
                    if (stored == TABLE_FULL) begin
                        fill_err <= 1'b1;
                    end else begin
                        stored <= stored + (IDX_W + 1)'(1);
                    end
                end

                if (cmd_start) begin
                    rd_idx   <= '0;
                    pf_valid <= 1'b0;
                end

                if (rd_en) begin
                    rd_idx   <= rd_idx_nx;
                    pf_valid <= 1'b1;
                end

                if (tail_acc) begin
                    sent <= sent_inc;
                end

                if (state == ST_RUN && state_nx == ST_GAP) begin
                    gap_cnt <= cur_gap;
                end else if (state == ST_GAP) begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end

                if (load_out) begin
                    out_valid <= 1'b1;
                    out_head  <= 1'b1;
                    out_tail  <= (pf_len <= LEN_W'(1));
                    out_seq   <= '0;
                    out_vc    <= pf_vc;
                    out_dest  <= pf_dest;
                    cur_last  <= (pf_len == '0) ? '0 : pf_len - LEN_W'(1);
                    cur_gap   <= pf_gap;
                end else if (accept && !out_tail) begin
                    out_head <= 1'b0;
                    out_seq  <= out_seq + LEN_W'(1);
                    out_tail <= ((out_seq + LEN_W'(1)) == cur_last);
                end else if (accept) begin
                    out_valid <= 1'b0;
                    out_head  <= 1'b0;
                    out_tail  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_gen_mc.sv
// Scoreboard bench for traffic_gen_mc, built with a 4-entry table so the
// table-full case is reachable. Stimulus pushes expected flits; a monitor
// pops and compares on every handshake.
module tb_traffic_gen_mc;
    import traffic_pkg::*;

    logic        clk, rst;
    logic [2:0]  op;
    logic [29:0] data;
    logic        out_valid, out_ready, out_head, out_tail;
    logic [1:0]  out_vc;
    logic [13:0] out_dest;
    logic [9:0]  out_seq;
    logic        busy, done, fill_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        head;
        logic        tail;
        logic [1:0]  vc;
        logic [13:0] dest;
        logic [9:0]  seq;
        int          idle;   // idle cycles expected before this flit, -1 = don't care
    } flit_t;

    flit_t exp_q[$];

    traffic_gen_mc #(.NUM_PKTS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_head  (out_head),
        .out_tail  (out_tail),
        .out_vc    (out_vc),
        .out_dest  (out_dest),
        .out_seq   (out_seq),
        .busy      (busy),
        .done      (done),
        .fill_err  (fill_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] pack_out();
        return {out_head, out_tail, out_vc, out_dest, out_seq};
    endfunction

    function automatic logic [27:0] pack_exp(input flit_t f);
        return {f.head, f.tail, f.vc, f.dest, f.seq};
    endfunction

    task automatic push_pkt(input int dest, input int vc, input int len, input int first_idle);
        flit_t f;
        int n;
        n = eff_len(len);
        for (int i = 0; i < n; i++) begin
            f.head = (i == 0);
            f.tail = (i == n - 1);
            f.vc   = 2'(vc);
            f.dest = 14'(dest);
            f.seq  = 10'(i);
            f.idle = (i == 0) ? first_idle : 0;
            exp_q.push_back(f);
        end
    endtask

    task automatic cmd(input logic [2:0] o, input logic [29:0] d);
        op   = o;
        data = d;
        @(posedge clk);
        #1;
        op   = 3'd0;
        data = '0;
    endtask

    task automatic fill(input int gap, input int len, input int vc, input int dest);
        desc_t d;
        d.gap  = 4'(gap);
        d.len  = 10'(len);
        d.vc   = 2'(vc);
        d.dest = 14'(dest);
        cmd(OP_FILL, d);
    endtask

    // Run until every expected flit has been seen, driving out_ready from pat.
    task automatic drain(input string name, input logic [15:0] pat, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
            #1;
            out_ready = pat[i % 16];
        end
        check({name, "_remaining_flits"}, exp_q.size(), 0);
        exp_q.delete();
        #1;
        out_ready = 1'b1;
    endtask

    // Monitor: compares every accepted flit, the idle run before it, and
    // field stability while stalled.
    initial begin
        int          idle;
        logic        stalled;
        logic [27:0] held;
        flit_t       f;
        idle    = 0;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle    = 0;
                stalled = 1'b0;
            end else begin
                if (stalled && out_valid) begin
                    check("stall_fields_stable", pack_out(), held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_flit: got 0x%0h, expected none (t=%0t)",
                                 pack_out(), $time);
                    end else begin
                        f = exp_q.pop_front();
                        check("flit", pack_out(), pack_exp(f));
                        if (f.idle >= 0) begin
                            check("idle_before_flit", idle, f.idle);
                        end
                    end
                    idle = 0;
                end else if (!out_valid) begin
                    idle++;
                end
                stalled = out_valid && !out_ready;
                held    = pack_out();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        op        = 3'd0;
        data      = '0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_head_tail", {out_head, out_tail}, 0);
        check("rst_vc_dest_seq", {out_vc, out_dest, out_seq}, 0);
        check("rst_status", {busy, done, fill_err}, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Three packets back to back: 2 flits, 1 flit, 3 flits.
        cmd(OP_INIT, 30'd3);
        fill(0, 2, 1, 5);
        fill(0, 1, 2, 9);
        fill(0, 3, 0, 7);
        push_pkt(5, 1, 2, -1);
        push_pkt(9, 2, 1, 0);
        push_pkt(7, 0, 3, 0);
        cmd(OP_START, 30'd0);
        check("t1_valid_after_start_edge", out_valid, 0);
        @(posedge clk);
        #1 check("t1_valid_one_edge_later", out_valid, 0);
        @(posedge clk);
        #1 check("t1_valid_two_edges_later", out_valid, 1);
        check("t1_busy_running", busy, 1);
        check("t1_done_running", done, 0);
        drain("t1", 16'hFFFF, 50);
        check("t1_done", done, 1);
        check("t1_busy_after", busy, 0);
        check("t1_valid_after", out_valid, 0);

        // Cyclic replay: 2 descriptors, 5 packets -> A B A B A.
        cmd(OP_INIT, 30'd5);
        fill(0, 1, 0, 'hA);
        fill(0, 1, 3, 'hB);
        push_pkt('hA, 0, 1, -1);
        push_pkt('hB, 3, 1, 0);
        push_pkt('hA, 0, 1, 0);
        push_pkt('hB, 3, 1, 0);
        push_pkt('hA, 0, 1, 0);
        cmd(OP_START, 30'd0);
        drain("t2", 16'hFFFF, 50);
        check("t2_done", done, 1);

        // Gap of 3 idle cycles between every tail and the next head.
        cmd(OP_INIT, 30'd3);
        fill(3, 2, 1, 'h11);
        fill(3, 1, 2, 'h22);
        push_pkt('h11, 1, 2, -1);
        push_pkt('h22, 2, 1, 3);
        push_pkt('h11, 1, 2, 3);
        cmd(OP_START, 30'd0);
        drain("t3", 16'hFFFF, 80);
        check("t3_done", done, 1);

        // Stalled len-4 packet: fields must hold, seq 0..3 without skips.
        cmd(OP_INIT, 30'd1);
        fill(0, 4, 2, 'h33);
        push_pkt('h33, 2, 4, -1);
        out_ready = 1'b0;
        cmd(OP_START, 30'd0);
        drain("t4", 16'h9A53, 200);
        check("t4_done", done, 1);

        // Table full: fifth FILL is dropped, stream replays the first four.
        cmd(OP_INIT, 30'd6);
        fill(0, 1, 0, 'h40);
        fill(0, 1, 0, 'h41);
        fill(0, 1, 0, 'h42);
        fill(0, 1, 0, 'h43);
        check("t5_fill_err_at_capacity", fill_err, 0);
        fill(0, 1, 0, 'h44);
        check("t5_fill_err_overflow", fill_err, 1);
        push_pkt('h40, 0, 1, -1);
        push_pkt('h41, 0, 1, 0);
        push_pkt('h42, 0, 1, 0);
        push_pkt('h43, 0, 1, 0);
        push_pkt('h40, 0, 1, 0);
        push_pkt('h41, 0, 1, 0);
        cmd(OP_START, 30'd0);
        drain("t5", 16'hFFFF, 60);
        check("t5_done", done, 1);

        // INIT mid-packet aborts; the reloaded table streams from scratch.
        cmd(OP_INIT, 30'd2);
        check("t6_fill_err_cleared", fill_err, 0);
        fill(0, 8, 1, 'h55);
        push_pkt('h55, 1, 3, -1);
        exp_q[2].tail = 1'b0;   // only the first three of eight flits go out
        cmd(OP_START, 30'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        cmd(OP_INIT, 30'd2);
        check("t6_abort_valid", out_valid, 0);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_done", done, 0);
        check("t6_flits_before_abort", exp_q.size(), 0);
        fill(0, 1, 0, 'h61);
        fill(0, 1, 1, 'h62);
        push_pkt('h61, 0, 1, -1);
        push_pkt('h62, 1, 1, 0);
        cmd(OP_START, 30'd0);
        drain("t6", 16'hFFFF, 50);
        check("t6_done", done, 1);

        // Asynchronous reset mid-RUN clears every output immediately.
        out_ready = 1'b0;
        cmd(OP_INIT, 30'd4);
        fill(0, 4, 3, 'h7F);
        cmd(OP_START, 30'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("t7_valid_before_rst", out_valid, 1);
        check("t7_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_fields", {out_head, out_tail, out_vc, out_dest, out_seq}, 0);
        check("t7_rst_status", {busy, done, fill_err}, 0);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
